booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier for the mipslite MULT/MULTU path.
- Retires one Booth digit per clock.
- Parametrised operand width.
- Runtime signed/unsigned mode.
- start/busy/done handshake plus a cancel input for pipeline flush.
- Sits beside the ALU in EX and feeds the HI/LO register pair.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- Derived E = WIDTH+2, extended operand width (even).
- Derived N = E/2, number of Booth digits = number of CALC cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- cancel  input  1  abort in-flight operation (pipeline flush).
- x  input  WIDTH  multiplicand; sampled with start.
- y  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  2*WIDTH  product {HI,LO}.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE.
  - busy = 0, done = 0, result = 0.
  - Internal accumulator and operand registers = 0.
- States and transitions:
  - IDLE: on start, go to CALC.
  - CALC: iterates for N cycles, then goes to DONE.
  - DONE: lasts 1 cycle, then goes to IDLE; a start in DONE goes directly to CALC.
- Operand capture (on the accepted-start edge):
  - X_e = x extended to E bits: sign-extend if is_signed, else zero-extend.
  - Y_e = y extended the same way.
  - Accumulator = 0; digit index i = 0.
- Digit recode, each CALC cycle:
  - Booth triplet is {Y_e[2i+1], Y_e[2i], Y_e[2i-1]}, with Y_e[-1] = 0.
  - Triplet-to-partial-product mapping:
    - 000 -> 0, 001 -> +X, 010 -> +X, 011 -> +2X
    - 100 -> -2X, 101 -> -X, 110 -> -X, 111 -> 0
  - The partial product is formed on 2E bits, sign-extended from E+1 bits, shifted left 2i.
  - It is added modulo 2^(2E) into the accumulator; i increments.
- Width rules:
  - Negation is two's-complement (invert plus carry-in); -2X of the most negative value must not overflow the E+1-bit intermediate.
  - result = accumulator[2*WIDTH-1:0]. Bits above are discarded; they are the correct sign/zero extension by construction.
- Latency:
  - Start accepted at edge k; busy = 1 during cycles k+1 .. k+N.
  - done = 1 and busy = 0 in cycle k+N+1.
  - result updates at the same edge done rises and holds until the next operation reaches DONE.
  - WIDTH=32 gives N=17, i.e. 18 cycles from start to done.
- Handshake:
  - start while busy is ignored; operands are not re-sampled.
  - start and done in the same cycle: the new operation is accepted and DONE goes straight to CALC. result keeps the old product until the new done.
- Cancel:
  - Takes effect at the next edge from CALC: go to IDLE, busy = 0, no done pulse, result unchanged.
  - cancel in IDLE or DONE has no effect. A DONE pulse already presented is not retracted.
  - start and cancel asserted together in IDLE: start wins.
  - start and cancel asserted together in CALC: cancel wins, start ignored.
- Reset mid-operation: immediate return to IDLE, outputs 0; no done pulse afterwards.
- Operands x, y and is_signed may change freely while busy; only captured values are used.

Test Plan:
- WIDTH=32, is_signed=0, x=y=0xFFFFFFFF, start pulse -> busy high 17 cycles, then done pulse with result=0xFFFFFFFE00000001.
- is_signed=1, x=0x80000000, y=0x80000000 -> result=0x4000000000000000; with y=0x00000001 -> result=0xFFFFFFFF80000000; with x=y=0xFFFFFFFF -> result=0x0000000000000001.
- Mid-op and back-to-back handshake, run in sequence:
  - During CALC, toggle x/y and pulse start again -> original product delivered at original cycle, no second operation.
  - Then start in the DONE cycle with x=3, y=5 -> next done after 17 more CALC cycles, result=15.
- Assert cancel on 5th CALC cycle -> busy falls next edge, done never pulses, result keeps prior value; subsequent start of 7*(-2) signed -> 0xFFFFFFFFFFFFFFF2.
- Assert rst asynchronously mid-CALC (between edges) -> busy, done, result drop to 0 immediately; after release, a fresh 0x12345678*0x9ABCDEF0 unsigned -> 0x0B00EA4E242D2080.
- WIDTH=8 instance, random 1000 signed and unsigned pairs against a reference multiply -> all match; done always exactly N+1=6 cycles after the accepted start.

Source files
------------

// File: rtl/booth_mul_if.sv
// Request/response bundle between the EX stage and the Booth multiplier.
// The EX stage drives the operands and controls; the multiplier returns status and the product.
interface booth_mul_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic               cancel;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [1:0]         dbg_state;

  modport master (
    output start, is_signed, cancel, x, y,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, is_signed, cancel, x, y,
    output busy, done, result, dbg_state
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for MULT/MULTU. It retires one Booth digit per clock
// and writes the {HI,LO} product when it finishes.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  booth_mul_if.slave  bus
);
  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int AW = 2 * E;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is taken only in IDLE or DONE. busy is high for exactly N CALC cycles.
  // done is a one-cycle pulse with result valid. cancel aborts CALC and produces no done.
  state_t             state_q, state_d;
  logic [E-1:0]       y_q, y_d;
  logic               prev_q, prev_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept;
  logic               last_digit;
  logic [E-1:0]       x_ext, y_ext;
  logic [2:0]         triplet;
  logic               pp_neg;
  logic [AW-1:0]      pp_mag, pp_add;
  logic               busy_o, done_o;

  assign accept     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_digit = (idx_q == CW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_CALC;
      S_CALC: begin
        if (bus.cancel)      state_d = S_IDLE;
        else if (last_digit) state_d = S_DONE;
      end
      S_DONE: state_d = bus.start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q == S_CALC);
    done_o = (state_q == S_DONE);
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

  // The multiplicand is kept sign-extended to 2E bits and pre-shifted by 2 per digit.
  // Because of this, +-X and +-2X need no shifter and never overflow the E+1-bit intermediate.
  always_comb begin
    x_ext   = bus.is_signed ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    y_ext   = bus.is_signed ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};
    triplet = {y_q[1], y_q[0], prev_q};

    pp_mag = '0;
    pp_neg = 1'b0;
    case (triplet)
      3'b001, 3'b010: pp_mag = mcand_q;
      3'b011:         pp_mag = mcand_q << 1;
      3'b100: begin
        pp_mag = mcand_q << 1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = mcand_q;
        pp_neg = 1'b1;
      end
      default: pp_mag = '0;
    endcase
    pp_add = pp_neg ? ~pp_mag : pp_mag;

    y_d      = y_q;
    prev_d   = prev_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;

    if (accept) begin
      y_d     = y_ext;
      prev_d  = 1'b0;
      mcand_d = {{(AW-E){x_ext[E-1]}}, x_ext};
      acc_d   = '0;
      idx_d   = '0;
    end else if ((state_q == S_CALC) && !bus.cancel) begin
      acc_d   = acc_q + pp_add + AW'(pp_neg);
      y_d     = {2'b00, y_q[E-1:2]};
      prev_d  = y_q[1];
      mcand_d = mcand_q << 2;
      idx_d   = idx_q + 1'b1;
      if (last_digit) result_d = acc_d[2*WIDTH-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      prev_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      y_q      <= y_d;
      prev_q   <= prev_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq. It uses a 32-bit instance for directed handshake cases
// and an 8-bit instance for random operand sweeps.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  booth_mul_if #(.WIDTH(32)) m32 ();
  booth_mul_if #(.WIDTH(8))  m8 ();

  booth_mul_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(m32));
  booth_mul_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(m8));

  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'd0, a};
    eb = s ? {{8{b[7]}}, b} : {8'd0, b};
    return ea * eb;
  endfunction

  // Scoreboards: pop one expected product on every done pulse
  always @(negedge clk) begin
    if (!rst && m32.done) begin
      if (exp_q.size() == 0) check_eq("sb32_unexpected_done", 64'(m32.done), 64'd0);
      else                   check_eq("sb32_result", m32.result, exp_q.pop_front());
    end
    if (!rst && m8.done) begin
      if (exp8_q.size() == 0) check_eq("sb8_unexpected_done", 64'(m8.done), 64'd0);
      else                    check_eq("sb8_result", 64'(m8.result), 64'(exp8_q.pop_front()));
    end
  end

  // Drivers: called at a negedge; they return at the negedge of the first CALC cycle
  task automatic start32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic push);
    m32.start = 1'b1;
    m32.is_signed = s;
    m32.x = a;
    m32.y = b;
    if (push) exp_q.push_back(ref_mul32(s, a, b));
    @(negedge clk);
    m32.start = 1'b0;
  endtask

  task automatic wait_done32(input int exp_lat, input int poke_at);
    int n = 1;
    while (!m32.done && n < 60) begin
      check_eq("busy32", 64'(m32.busy), 64'd1);
      if (n == poke_at) begin
        m32.start = 1'b1;
        m32.x = $urandom;
        m32.y = $urandom;
        m32.is_signed = ~m32.is_signed;
      end else begin
        m32.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    m32.start = 1'b0;
    check_eq("lat32", 64'(n), 64'(exp_lat));
    check_eq("busy_at_done32", 64'(m32.busy), 64'd0);
  endtask

  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    m8.start = 1'b1;
    m8.is_signed = s;
    m8.x = a;
    m8.y = b;
    exp8_q.push_back(ref_mul8(s, a, b));
    @(negedge clk);
    m8.start = 1'b0;
    m8.x = 8'($urandom);
    m8.y = 8'($urandom);
  endtask

  task automatic wait_done8(input int exp_lat);
    int n = 1;
    while (!m8.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("lat8", 64'(n), 64'(exp_lat));
  endtask

  task automatic count_done32(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (m32.done) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] corner [4];
    int pulses;
    corner = '{8'h80, 8'hFF, 8'h7F, 8'h00};

    rst = 1'b1;
    m32.start = 1'b0; m32.is_signed = 1'b0; m32.cancel = 1'b0; m32.x = '0; m32.y = '0;
    m8.start  = 1'b0; m8.is_signed  = 1'b0; m8.cancel  = 1'b0; m8.x  = '0; m8.y  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(m32.busy), 64'd0);
    check_eq("rst_done", 64'(m32.done), 64'd0);
    check_eq("rst_result", m32.result, 64'd0);
    check_eq("rst_result8", 64'(m8.result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned max * max
    start32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done32(18, 0);
    check_eq("umax", m32.result, 64'hFFFFFFFE00000001);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(m32.done), 64'd0);

    // Signed corners
    start32(1'b1, 32'h80000000, 32'h80000000, 1'b1);
    wait_done32(18, 0);
    check_eq("smin_smin", m32.result, 64'h4000000000000000);
    start32(1'b1, 32'h80000000, 32'h00000001, 1'b1);
    wait_done32(18, 0);
    check_eq("smin_one", m32.result, 64'hFFFFFFFF80000000);
    start32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done32(18, 0);
    check_eq("sneg1_sneg1", m32.result, 64'h0000000000000001);
    @(negedge clk);

    // Start pulse and operand changes during CALC are ignored
    start32(1'b0, 32'hABCD1234, 32'h00FF00FF, 1'b1);
    wait_done32(18, 5);
    check_eq("midop_result", m32.result, ref_mul32(1'b0, 32'hABCD1234, 32'h00FF00FF));
    // Start in the DONE cycle goes straight back to CALC
    start32(1'b0, 32'd3, 32'd5, 1'b1);
    check_eq("hold_result", m32.result, ref_mul32(1'b0, 32'hABCD1234, 32'h00FF00FF));
    wait_done32(18, 0);
    check_eq("b2b_3x5", m32.result, 64'd15);
    @(negedge clk);

    // Cancel with a simultaneous start on the 5th CALC cycle
    start32(1'b1, 32'h0000DEAD, 32'h0000BEEF, 1'b0);
    repeat (4) @(negedge clk);
    m32.cancel = 1'b1;
    m32.start = 1'b1;
    m32.x = 32'h11111111;
    m32.y = 32'h22222222;
    @(negedge clk);
    m32.cancel = 1'b0;
    m32.start = 1'b0;
    check_eq("cancel_busy", 64'(m32.busy), 64'd0);
    check_eq("cancel_state", 64'(m32.dbg_state), 64'd0);
    check_eq("cancel_result", m32.result, 64'd15);
    count_done32(25, pulses);
    check_eq("cancel_no_done", 64'(pulses), 64'd0);

    // Start together with cancel in IDLE: start is taken
    m32.cancel = 1'b1;
    start32(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
    m32.cancel = 1'b0;
    wait_done32(18, 0);
    check_eq("s7xm2", m32.result, 64'hFFFFFFFFFFFFFFF2);
    @(negedge clk);

    // Asynchronous reset between edges during CALC
    start32(1'b0, 32'h00C0FFEE, 32'h0BADF00D, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", 64'(m32.busy), 64'd0);
    check_eq("arst_done", 64'(m32.done), 64'd0);
    check_eq("arst_result", m32.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done32(25, pulses);
    check_eq("arst_no_done", 64'(pulses), 64'd0);
    start32(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done32(18, 0);
    check_eq("post_rst", m32.result, 64'h0B00EA4E242D2080);
    @(negedge clk);

    // 8-bit sweep: corner pairs first, then random pairs, sometimes started in the DONE cycle
    for (int i = 0; i < 1000; i++) begin
      logic       s;
      logic [7:0] a, b;
      s = (i % 2) == 1;
      if (i < 32) begin
        a = corner[(i / 2) % 4];
        b = corner[(i / 8) % 4];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      start8(s, a, b);
      wait_done8(6);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    check_eq("sb32_drained", 64'(exp_q.size()), 64'd0);
    check_eq("sb8_drained", 64'(exp8_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
